// File: rtl/bsc_wbuf.sv
// bsc_wbuf: posted write buffer between the internal bus master and the BSC IBUS port.
// Build option WBUF_MERGE_EN: fold a posted write into the newest un-issued entry with the same word address.
module bsc_wbuf #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic [31:0] UP_A,
   input  logic [31:0] UP_DI,
   output logic [31:0] UP_DO,
   input  logic [3:0]  UP_BA,
   input  logic        UP_WE,
   input  logic        UP_REQ,
   input  logic        UP_LOCK,
   output logic        UP_BUSY,
   output logic [31:0] DN_A,
   output logic [31:0] DN_DO,
   input  logic [31:0] DN_DI,
   output logic [3:0]  DN_BA,
   output logic        DN_WE,
   output logic        DN_REQ,
   output logic        DN_LOCK,
   input  logic        DN_BUSY,
   output logic        EMPTY
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   typedef enum logic [1:0] {
      PT_IDLE  = 2'd0,
      PT_DRAIN = 2'd1,
      PT_ISSUE = 2'd2,
      PT_WAIT  = 2'd3
   } pt_state_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_REQ  = 1'b1
   } d_state_e;

   pt_state_e     pt_state_q, pt_state_d;
   d_state_e      d_state_q, d_state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_a_q   [DEPTH];
   logic [DW-1:0] mem_a_d   [DEPTH];
   logic [DW-1:0] mem_dat_q [DEPTH];
   logic [DW-1:0] mem_dat_d [DEPTH];
   logic [BW-1:0] mem_ba_q  [DEPTH];
   logic [BW-1:0] mem_ba_d  [DEPTH];
   logic [DW-1:0] dn_a_q, dn_a_d, dn_do_q, dn_do_d, up_do_q, up_do_d;
   logic [BW-1:0] dn_ba_q, dn_ba_d;
   logic          dn_we_q, dn_we_d, dn_req_q, dn_req_d, dn_lock_q, dn_lock_d;
   logic          seen_busy_q, seen_busy_d, pt_done_q, pt_done_d;

   logic [AW-1:0] wr_idx, rd_idx;
   logic          full, empty, ext_addr, postable, slot_ok, accept_post, d_load, dn_cpl;

   assign wr_idx   = wr_ptr_q[AW-1:0];
   assign rd_idx   = rd_ptr_q[AW-1:0];
   assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   // External area: A[31:27] matches 00?00
   assign ext_addr = (UP_A[31:30] == 2'b00) && (UP_A[28:27] == 2'b00);
   assign postable = UP_REQ && UP_WE && !UP_LOCK && ext_addr;
   assign d_load   = (d_state_q == D_IDLE) && !empty
                     && ((pt_state_q == PT_IDLE) || (pt_state_q == PT_DRAIN));
   assign dn_cpl   = dn_req_q && seen_busy_q && !DN_BUSY;

`ifdef WBUF_MERGE_EN
   logic [AW-1:0] new_idx;
   logic          merge_hit;
   assign new_idx   = AW'(wr_ptr_q - PW'(1));
   // The head is off limits once the drain engine has latched or is latching it
   assign merge_hit = postable && !empty
                      && (mem_a_q[new_idx][31:2] == UP_A[31:2])
                      && !((new_idx == rd_idx) && ((d_state_q == D_REQ) || d_load));
   assign slot_ok   = !full || merge_hit;
`else
   assign slot_ok   = !full;
`endif

   assign accept_post = postable && slot_ok && (pt_state_q == PT_IDLE);
   assign UP_BUSY     = UP_REQ && !(accept_post || pt_done_q);

   always_comb begin
      pt_state_d  = pt_state_q;
      d_state_d   = d_state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_a_d     = mem_a_q;
      mem_dat_d   = mem_dat_q;
      mem_ba_d    = mem_ba_q;
      dn_a_d      = dn_a_q;
      dn_do_d     = dn_do_q;
      dn_ba_d     = dn_ba_q;
      dn_we_d     = dn_we_q;
      dn_req_d    = dn_req_q;
      dn_lock_d   = dn_lock_q;
      up_do_d     = up_do_q;
      seen_busy_d = seen_busy_q;
      pt_done_d   = 1'b0;

      // Shared downstream handshake: busy must be seen before a low BUSY counts as completion
      if (dn_req_q && DN_BUSY) seen_busy_d = 1'b1;
      if (dn_cpl) begin
         dn_req_d    = 1'b0;
         seen_busy_d = 1'b0;
      end

      if (accept_post) begin
`ifdef WBUF_MERGE_EN
         if (merge_hit) begin
            for (int i = 0; i < int'(BW); i++) begin
               if (UP_BA[i]) mem_dat_d[new_idx][i*8 +: 8] = UP_DI[i*8 +: 8];
            end
            mem_ba_d[new_idx] = mem_ba_q[new_idx] | UP_BA;
         end else
`endif
         begin
            mem_a_d[wr_idx]   = UP_A;
            mem_dat_d[wr_idx] = UP_DI;
            mem_ba_d[wr_idx]  = UP_BA;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
      end

      case (d_state_q)
         D_IDLE: begin
            if (d_load) begin
               dn_a_d    = mem_a_q[rd_idx];
               dn_do_d   = mem_dat_q[rd_idx];
               dn_ba_d   = mem_ba_q[rd_idx];
               dn_we_d   = 1'b1;
               dn_lock_d = 1'b0;
               dn_req_d  = 1'b1;
               d_state_d = D_REQ;
            end
         end
         D_REQ: begin
            if (dn_cpl) begin
               rd_ptr_d  = rd_ptr_q + PW'(1);
               d_state_d = D_IDLE;
            end
         end
         default: d_state_d = D_IDLE;
      endcase

      // pt_done_q blocks a restart on the very request that is being released
      case (pt_state_q)
         PT_IDLE: begin
            if (UP_REQ && !postable && !pt_done_q) pt_state_d = PT_DRAIN;
         end
         PT_DRAIN: begin
            if (empty && (d_state_q == D_IDLE)) pt_state_d = PT_ISSUE;
         end
         PT_ISSUE: begin
            dn_a_d     = UP_A;
            dn_do_d    = UP_DI;
            dn_ba_d    = UP_BA;
            dn_we_d    = UP_WE;
            dn_lock_d  = UP_LOCK;
            dn_req_d   = 1'b1;
            pt_state_d = PT_WAIT;
         end
         PT_WAIT: begin
            if (dn_cpl) begin
               up_do_d    = DN_DI;
               pt_done_d  = UP_REQ;
               pt_state_d = PT_IDLE;
            end
         end
         default: pt_state_d = PT_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pt_state_q  <= PT_IDLE;
         d_state_q   <= D_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_a_q[i]   <= '0;
            mem_dat_q[i] <= '0;
            mem_ba_q[i]  <= '0;
         end
         dn_a_q      <= '0;
         dn_do_q     <= '0;
         dn_ba_q     <= '0;
         dn_we_q     <= 1'b0;
         dn_req_q    <= 1'b0;
         dn_lock_q   <= 1'b0;
         up_do_q     <= '0;
         seen_busy_q <= 1'b0;
         pt_done_q   <= 1'b0;
      end else if (CE_R) begin
         pt_state_q  <= pt_state_d;
         d_state_q   <= d_state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_a_q     <= mem_a_d;
         mem_dat_q   <= mem_dat_d;
         mem_ba_q    <= mem_ba_d;
         dn_a_q      <= dn_a_d;
         dn_do_q     <= dn_do_d;
         dn_ba_q     <= dn_ba_d;
         dn_we_q     <= dn_we_d;
         dn_req_q    <= dn_req_d;
         dn_lock_q   <= dn_lock_d;
         up_do_q     <= up_do_d;
         seen_busy_q <= seen_busy_d;
         pt_done_q   <= pt_done_d;
      end
   end

   assign UP_DO   = up_do_q;
   assign DN_A    = dn_a_q;
   assign DN_DO   = dn_do_q;
   assign DN_BA   = dn_ba_q;
   assign DN_WE   = dn_we_q;
   assign DN_REQ  = dn_req_q;
   assign DN_LOCK = dn_lock_q;
   assign EMPTY   = empty && !dn_req_q;

endmodule
